pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 59 +++++
 rtl/pipeline_ctrl_if.sv | 75 +++++++
 rtl/pipeline_ctrl_stall_counter.sv | 33 +++
 rtl/pipeline_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
// STALL_PERF_EN selects the optional performance counters.
package pipeline_ctrl_pkg;

    localparam int CNT_W = 32;

`ifdef STALL_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_IWAIT = 2'b01,
        ST_DWAIT = 2'b10
    } state_e;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_EXC = 2'b10;

    typedef struct packed {
        logic       pc_we;
        logic       if_id_we;
        logic       id_ex_we;
        logic       ex_mem_we;
        logic       if_id_flush;
        logic       id_ex_flush;
        logic       ex_mem_flush;
        logic       mem_wb_flush;
        logic [1:0] pc_src;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN = '{
        pc_we:        1'b1,
        if_id_we:     1'b1,
        id_ex_we:     1'b1,
        ex_mem_we:    1'b1,
        if_id_flush:  1'b0,
        id_ex_flush:  1'b0,
        ex_mem_flush: 1'b0,
        mem_wb_flush: 1'b0,
        pc_src:       PC_SEQ
    };

    localparam ctrl_t CTRL_RST = '{
        pc_we:        1'b0,
        if_id_we:     1'b0,
        id_ex_we:     1'b0,
        ex_mem_we:    1'b0,
        if_id_flush:  1'b1,
        id_ex_flush:  1'b1,
        ex_mem_flush: 1'b1,
        mem_wb_flush: 1'b1,
        pc_src:       PC_SEQ
    };

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/cache requests in, stage enables/flushes out.
// Perf counter and preload signals exist only with STALL_PERF_EN.
interface pipeline_ctrl_if;
    import pipeline_ctrl_pkg::*;

    logic       lu_stall;
    logic       icache_busy;
    logic       dcache_busy;
    logic       branch_taken;
    logic       exception;

    logic       pc_we;
    logic       if_id_we;
    logic       id_ex_we;
    logic       ex_mem_we;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ex_mem_flush;
    logic       mem_wb_flush;
    logic [1:0] pc_src;

    state_e     dbg_state;
    logic       dbg_redir_pend;

`ifdef STALL_PERF_EN
    logic [CNT_W-1:0] perf_lu;
    logic [CNT_W-1:0] perf_ic;
    logic [CNT_W-1:0] perf_dc;
    logic [CNT_W-1:0] perf_redir;
    // one preload strobe per counter: {redir, dc, ic, lu}
    logic [3:0]       perf_ld;
    logic [CNT_W-1:0] perf_ld_val;

    modport master (
        output lu_stall, icache_busy, dcache_busy,
        output branch_taken, exception,
        output perf_ld, perf_ld_val,
        input  pc_we, if_id_we, id_ex_we, ex_mem_we,
        input  if_id_flush, id_ex_flush,
        input  ex_mem_flush, mem_wb_flush,
        input  pc_src, dbg_state, dbg_redir_pend,
        input  perf_lu, perf_ic, perf_dc, perf_redir
    );

    modport slave (
        input  lu_stall, icache_busy, dcache_busy,
        input  branch_taken, exception,
        input  perf_ld, perf_ld_val,
        output pc_we, if_id_we, id_ex_we, ex_mem_we,
        output if_id_flush, id_ex_flush,
        output ex_mem_flush, mem_wb_flush,
        output pc_src, dbg_state, dbg_redir_pend,
        output perf_lu, perf_ic, perf_dc, perf_redir
    );
`else
    modport master (
        output lu_stall, icache_busy, dcache_busy,
        output branch_taken, exception,
        input  pc_we, if_id_we, id_ex_we, ex_mem_we,
        input  if_id_flush, id_ex_flush,
        input  ex_mem_flush, mem_wb_flush,
        input  pc_src, dbg_state, dbg_redir_pend
    );

    modport slave (
        input  lu_stall, icache_busy, dcache_busy,
        input  branch_taken, exception,
        output pc_we, if_id_we, id_ex_we, ex_mem_we,
        output if_id_flush, id_ex_flush,
        output ex_mem_flush, mem_wb_flush,
        output pc_src, dbg_state, dbg_redir_pend
    );
`endif

endinterface

// File: rtl/pipeline_ctrl_stall_counter.sv
// 32-bit saturating event counter with sync clear and preload.
// Built only when STALL_PERF_EN is defined.
`ifdef STALL_PERF_EN
module stall_counter
    import pipeline_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_ld,
    input  logic [CNT_W-1:0] i_ld_val,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_sat;

    assign w_sat = &r_cnt;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_ld) begin
            r_cnt <= i_ld_val;
        end else if (i_en && !w_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule
`endif

// File: rtl/pipeline_ctrl.sv
// Stall/flush/redirect arbiter for the five-stage pipeline.
// Define STALL_PERF_EN to add the stall/redirect perf counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    pipeline_ctrl_if.slave bus
);

    state_e r_state;
    state_e w_state_nxt;
    logic   r_redir_pend;
    logic   w_redir_pend_nxt;

    logic   w_win_dc;
    logic   w_win_ex;
    logic   w_win_br;
    logic   w_win_lu;
    logic   w_win_ic;
    logic   w_redir;
    ctrl_t  w_ctrl;

    // one-hot winner of the per-cycle priority chain
    assign w_win_dc = bus.dcache_busy;
    assign w_win_ex = !bus.dcache_busy && bus.exception;
    assign w_win_br = !bus.dcache_busy && !bus.exception
                   && bus.branch_taken;
    assign w_win_lu = !bus.dcache_busy && !bus.exception
                   && !bus.branch_taken && bus.lu_stall;
    assign w_win_ic = !bus.dcache_busy && !bus.exception
                   && !bus.branch_taken && !bus.lu_stall
                   && bus.icache_busy;
    assign w_redir  = w_win_ex || w_win_br;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = ST_RUN;
        if (bus.dcache_busy) begin
            w_state_nxt = ST_DWAIT;
        end else if (bus.icache_busy) begin
            w_state_nxt = ST_IWAIT;
        end
    end

    // a fetch already in flight when we redirect returns wrong-path data
    always_comb begin
        w_redir_pend_nxt = r_redir_pend;
        if (w_redir && bus.icache_busy) begin
            w_redir_pend_nxt = 1'b1;
        end else if (r_redir_pend && !bus.icache_busy) begin
            w_redir_pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_redir_pend <= 1'b0;
        end else begin
            r_redir_pend <= w_redir_pend_nxt;
        end
    end

    always_comb begin
        w_ctrl = CTRL_RUN;
        unique case (1'b1)
            w_win_dc: begin
                w_ctrl.pc_we        = 1'b0;
                w_ctrl.if_id_we     = 1'b0;
                w_ctrl.id_ex_we     = 1'b0;
                w_ctrl.ex_mem_we    = 1'b0;
                w_ctrl.mem_wb_flush = 1'b1;
            end
            w_win_ex: begin
                w_ctrl.pc_src       = PC_EXC;
                w_ctrl.if_id_flush  = 1'b1;
                w_ctrl.id_ex_flush  = 1'b1;
                w_ctrl.ex_mem_flush = 1'b1;
            end
            w_win_br: begin
                w_ctrl.pc_src       = PC_BR;
                w_ctrl.if_id_flush  = 1'b1;
                w_ctrl.id_ex_flush  = 1'b1;
            end
            w_win_lu: begin
                w_ctrl.pc_we        = 1'b0;
                w_ctrl.if_id_we     = 1'b0;
                w_ctrl.id_ex_flush  = 1'b1;
            end
            w_win_ic: begin
                w_ctrl.pc_we        = 1'b0;
                w_ctrl.if_id_flush  = 1'b1;
            end
            default: begin
            end
        endcase
        if (r_redir_pend) begin
            w_ctrl.if_id_flush = 1'b1;
        end
        if (reset) begin
            w_ctrl = CTRL_RST;
        end
    end

    assign bus.pc_we          = w_ctrl.pc_we;
    assign bus.if_id_we       = w_ctrl.if_id_we;
    assign bus.id_ex_we       = w_ctrl.id_ex_we;
    assign bus.ex_mem_we      = w_ctrl.ex_mem_we;
    assign bus.if_id_flush    = w_ctrl.if_id_flush;
    assign bus.id_ex_flush    = w_ctrl.id_ex_flush;
    assign bus.ex_mem_flush   = w_ctrl.ex_mem_flush;
    assign bus.mem_wb_flush   = w_ctrl.mem_wb_flush;
    assign bus.pc_src         = w_ctrl.pc_src;
    assign bus.dbg_state      = r_state;
    assign bus.dbg_redir_pend = r_redir_pend;

`ifdef STALL_PERF_EN
    logic [CNT_W-1:0] w_perf_lu;
    logic [CNT_W-1:0] w_perf_ic;
    logic [CNT_W-1:0] w_perf_dc;
    logic [CNT_W-1:0] w_perf_redir;

    stall_counter u_cnt_lu (
        .clk      (clk),
        .i_clr    (reset),
        .i_en     (w_win_lu),
        .i_ld     (bus.perf_ld[0]),
        .i_ld_val (bus.perf_ld_val),
        .o_cnt    (w_perf_lu)
    );

    stall_counter u_cnt_ic (
        .clk      (clk),
        .i_clr    (reset),
        .i_en     (w_win_ic),
        .i_ld     (bus.perf_ld[1]),
        .i_ld_val (bus.perf_ld_val),
        .o_cnt    (w_perf_ic)
    );

    stall_counter u_cnt_dc (
        .clk      (clk),
        .i_clr    (reset),
        .i_en     (w_win_dc),
        .i_ld     (bus.perf_ld[2]),
        .i_ld_val (bus.perf_ld_val),
        .o_cnt    (w_perf_dc)
    );

    stall_counter u_cnt_redir (
        .clk      (clk),
        .i_clr    (reset),
        .i_en     (w_redir),
        .i_ld     (bus.perf_ld[3]),
        .i_ld_val (bus.perf_ld_val),
        .o_cnt    (w_perf_redir)
    );

    assign bus.perf_lu    = w_perf_lu;
    assign bus.perf_ic    = w_perf_ic;
    assign bus.perf_dc    = w_perf_dc;
    assign bus.perf_redir = w_perf_redir;
`else
    // control-only build: no counter state at all
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: priority table plus stall,
// redirect-pending, reset and (with STALL_PERF_EN) counter sequences.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    typedef struct {
        logic [4:0] in;
        ctrl_t      exp;
        state_e     st;
    } vec_t;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    pipeline_ctrl_if bus ();

    pipeline_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctrl_t mk(input logic [3:0] we,
                                 input logic [3:0] fl,
                                 input logic [1:0] src);
        return {we, fl, src};
    endfunction

    function automatic vec_t mkv(input logic [4:0] in,
                                 input ctrl_t e,
                                 input state_e s);
        vec_t v;
        v.in  = in;
        v.exp = e;
        v.st  = s;
        return v;
    endfunction

    // {dc, ex, br, lu, ic}
    task automatic drive(input logic [4:0] v);
        bus.dcache_busy  = v[4];
        bus.exception    = v[3];
        bus.branch_taken = v[2];
        bus.lu_stall     = v[1];
        bus.icache_busy  = v[0];
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctrl(input string nm, input ctrl_t e);
        ctrl_t a;
        a = {bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we,
             bus.if_id_flush, bus.id_ex_flush,
             bus.ex_mem_flush, bus.mem_wb_flush, bus.pc_src};
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %b required %b", nm, a, e);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, a, e);
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        drive(5'b00000);
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    ctrl_t c_run, c_lu, c_ic, c_br, c_ex, c_dc, c_rst, c_pend;
    vec_t  vecs[12];

    initial begin
        n_chk = 0;
        n_err = 0;
        c_run  = mk(4'b1111, 4'b0000, 2'b00);
        c_lu   = mk(4'b0011, 4'b0100, 2'b00);
        c_ic   = mk(4'b0111, 4'b1000, 2'b00);
        c_br   = mk(4'b1111, 4'b1100, 2'b01);
        c_ex   = mk(4'b1111, 4'b1110, 2'b10);
        c_dc   = mk(4'b0000, 4'b0001, 2'b00);
        c_rst  = mk(4'b0000, 4'b1111, 2'b00);
        c_pend = mk(4'b1111, 4'b1000, 2'b00);

        vecs[0]  = mkv(5'b00000, c_run, ST_RUN);
        vecs[1]  = mkv(5'b00010, c_lu,  ST_RUN);
        vecs[2]  = mkv(5'b00001, c_ic,  ST_IWAIT);
        vecs[3]  = mkv(5'b00100, c_br,  ST_RUN);
        vecs[4]  = mkv(5'b01000, c_ex,  ST_RUN);
        vecs[5]  = mkv(5'b01100, c_ex,  ST_RUN);
        vecs[6]  = mkv(5'b11111, c_dc,  ST_DWAIT);
        vecs[7]  = mkv(5'b00111, c_br,  ST_IWAIT);
        vecs[8]  = mkv(5'b00011, c_lu,  ST_IWAIT);
        vecs[9]  = mkv(5'b10000, c_dc,  ST_DWAIT);
        vecs[10] = mkv(5'b10010, c_dc,  ST_DWAIT);
        vecs[11] = mkv(5'b01010, c_ex,  ST_RUN);

`ifdef STALL_PERF_EN
        bus.perf_ld     = 4'b0000;
        bus.perf_ld_val = '0;
`endif

        // reset dominates whatever the inputs ask for
        reset = 1'b1;
        drive(5'b00110);
        @(negedge clk);
        chk_ctrl("reset_ctrl", c_rst);
        chk("reset_state", 32'(bus.dbg_state), 32'(ST_RUN));
        chk("reset_pend", 32'(bus.dbg_redir_pend), 32'd0);
        cyc();
        reset = 1'b0;

        // single load-use stall
        reset_dut();
        drive(5'b00010);
        @(negedge clk);
        chk_ctrl("lu_stall", c_lu);
        cyc();
        drive(5'b00000);
        @(negedge clk);
        chk_ctrl("lu_after", c_run);
`ifdef STALL_PERF_EN
        chk("perf_lu", bus.perf_lu, 32'd1);
`endif
        cyc();

        // dcache freeze hides a pending branch for 3 cycles
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            drive(5'b10100);
            @(negedge clk);
            chk_ctrl($sformatf("dc_freeze%0d", k), c_dc);
            cyc();
            chk($sformatf("dc_state%0d", k), 32'(bus.dbg_state),
                32'(ST_DWAIT));
        end
        drive(5'b00100);
        @(negedge clk);
        chk_ctrl("dc_then_br", c_br);
`ifdef STALL_PERF_EN
        chk("perf_dc", bus.perf_dc, 32'd3);
`endif
        cyc();
        chk("dc_exit_state", 32'(bus.dbg_state), 32'(ST_RUN));

        // priority table, each vector followed by an idle cycle
        reset_dut();
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].in);
            @(negedge clk);
            chk_ctrl($sformatf("vec%0d_ctrl", i), vecs[i].exp);
            cyc();
            chk($sformatf("vec%0d_state", i), 32'(bus.dbg_state),
                32'(vecs[i].st));
            drive(5'b00000);
            @(negedge clk);
            cyc();
        end

        // icache busy 4 cycles, branch in cycle 2
        reset_dut();
        drive(5'b00001);
        @(negedge clk);
        chk_ctrl("ic_c1", c_ic);
        cyc();
        drive(5'b00101);
        @(negedge clk);
        chk_ctrl("ic_c2_br", c_br);
        cyc();
        drive(5'b00001);
        @(negedge clk);
        chk_ctrl("ic_c3", c_ic);
        chk("ic_c3_pend", 32'(bus.dbg_redir_pend), 32'd1);
        cyc();
        @(negedge clk);
        chk_ctrl("ic_c4", c_ic);
        cyc();
        drive(5'b00000);
        @(negedge clk);
        chk_ctrl("ic_c5_discard", c_pend);
        chk("ic_c5_pend", 32'(bus.dbg_redir_pend), 32'd1);
        cyc();
        @(negedge clk);
        chk_ctrl("ic_c6", c_run);
        chk("ic_c6_pend", 32'(bus.dbg_redir_pend), 32'd0);
        cyc();

        // redirect in the cycle icache_busy drops: no pending flag
        reset_dut();
        drive(5'b00001);
        @(negedge clk);
        cyc();
        drive(5'b00100);
        @(negedge clk);
        chk_ctrl("fall_br", c_br);
        cyc();
        chk("fall_pend", 32'(bus.dbg_redir_pend), 32'd0);
        drive(5'b00000);
        @(negedge clk);
        chk_ctrl("fall_after", c_run);
        cyc();

        // back-to-back redirects under icache busy
        reset_dut();
        drive(5'b00101);
        @(negedge clk);
        chk_ctrl("b2b_br1", c_br);
        cyc();
        drive(5'b01001);
        @(negedge clk);
        chk_ctrl("b2b_ex", c_ex);
        cyc();
        chk("b2b_pend", 32'(bus.dbg_redir_pend), 32'd1);
        drive(5'b00101);
        @(negedge clk);
        chk_ctrl("b2b_br2", c_br);
        cyc();
        drive(5'b00000);
        @(negedge clk);
        chk_ctrl("b2b_discard", c_pend);
        cyc();
        chk("b2b_clear", 32'(bus.dbg_redir_pend), 32'd0);

        // exception beats branch, one accepted redirect
        reset_dut();
        drive(5'b01100);
        @(negedge clk);
        chk_ctrl("ex_br", c_ex);
        cyc();
        drive(5'b00000);
`ifdef STALL_PERF_EN
        chk("perf_redir", bus.perf_redir, 32'd1);
`endif

        // reset in the middle of a dcache freeze
        reset_dut();
        drive(5'b10000);
        cyc();
        cyc();
        chk("dw_state", 32'(bus.dbg_state), 32'(ST_DWAIT));
        reset = 1'b1;
        @(negedge clk);
        chk_ctrl("dw_reset_ctrl", c_rst);
        cyc();
        reset = 1'b0;
        drive(5'b00000);
        chk("dw_reset_state", 32'(bus.dbg_state), 32'(ST_RUN));
`ifdef STALL_PERF_EN
        chk("dw_reset_perf_dc", bus.perf_dc, 32'd0);
`endif
        @(negedge clk);
        chk_ctrl("dw_release", c_run);
        cyc();

`ifdef STALL_PERF_EN
        // saturation of the icache stall counter
        reset_dut();
        bus.perf_ld     = 4'b0010;
        bus.perf_ld_val = 32'hFFFF_FFFE;
        cyc();
        bus.perf_ld = 4'b0000;
        chk("sat_preload", bus.perf_ic, 32'hFFFF_FFFE);
        drive(5'b00001);
        cyc();
        chk("sat_c1", bus.perf_ic, 32'hFFFF_FFFF);
        cyc();
        cyc();
        chk("sat_c3", bus.perf_ic, 32'hFFFF_FFFF);
        drive(5'b00000);
        cyc();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
